// File: rtl/ad9434_cap_ctrl.sv
// AD9434 capture sequencer: arm, wait for a synced trigger edge, then pack a timed
// window of 12-bit samples two-per-word into the capture BRAM with a done/ack handshake.
module ad9434_cap_ctrl #(
   parameter int unsigned CLK_PER_US  = 200,
   parameter int unsigned DEPTH_WORDS = 4096
) (
   input  logic        clk_200m,
   input  logic        rst,
   input  logic        i_arm,
   input  logic        i_trig,
   input  logic        i_abort,
   input  logic [9:0]  i_us_capture,
   input  logic        i_adc_valid,
   input  logic [11:0] i_adc_data,
   input  logic        i_done_ack,
   output logic [31:0] o_bram_addr,
   output logic [31:0] o_bram_data,
   output logic        o_bram_ena,
   output logic        o_bram_wea,
   output logic        o_busy,
   output logic        o_done,
   output logic        o_trunc,
   output logic [15:0] o_word_cnt,
   output logic [2:0]  o_state
);

   typedef enum logic [2:0] {
      StIdle    = 3'd0,
      StArmed   = 3'd1,
      StCapture = 3'd2,
      StFlush   = 3'd3,
      StDone    = 3'd4
   } state_e;

   state_e      state_q, state_d;
   logic        trig_s1_q, trig_s2_q, trig_s3_q;
   logic [31:0] win_lim_q, win_lim_d;
   logic [31:0] win_cnt_q, win_cnt_d;
   logic        pend_q, pend_d;
   logic [11:0] pair_lo_q, pair_lo_d;
   logic [15:0] word_cnt_q, word_cnt_d;
   logic        trunc_q, trunc_d;
   logic        ena_q, ena_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] data_q, data_d;

   logic        trig_rise;
   logic        wr_issue;
   logic [31:0] wr_data;

   assign trig_rise = trig_s2_q & ~trig_s3_q;

   // Trigger synchroniser plus edge-detect register
   always_ff @(posedge clk_200m) begin
      if (rst) begin
         trig_s1_q <= 1'b0;
         trig_s2_q <= 1'b0;
         trig_s3_q <= 1'b0;
      end else begin
         trig_s1_q <= i_trig;
         trig_s2_q <= trig_s1_q;
         trig_s3_q <= trig_s2_q;
      end
   end

   // Sequencer next-state, sample packing and write issue
   always_comb begin
      state_d    = state_q;
      win_lim_d  = win_lim_q;
      win_cnt_d  = win_cnt_q;
      pend_d     = pend_q;
      pair_lo_d  = pair_lo_q;
      word_cnt_d = word_cnt_q;
      trunc_d    = trunc_q;
      wr_issue   = 1'b0;
      wr_data    = '0;

      if (i_abort) begin
         // Writes already registered complete on their own; nothing new is issued
         state_d = StIdle;
         pend_d  = 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (i_arm) state_d = StArmed;
            end
            StArmed: begin
               if (trig_rise) begin
                  win_lim_d  = 32'(i_us_capture) * CLK_PER_US;
                  win_cnt_d  = '0;
                  word_cnt_d = '0;
                  trunc_d    = 1'b0;
                  pend_d     = 1'b0;
                  pair_lo_d  = '0;
                  state_d    = (i_us_capture == 10'd0) ? StFlush : StCapture;
               end
            end
            StCapture: begin
               win_cnt_d = win_cnt_q + 32'd1;
               if (i_adc_valid) begin
                  if (!pend_q) begin
                     pair_lo_d = i_adc_data;
                     pend_d    = 1'b1;
                  end else begin
                     wr_issue   = 1'b1;
                     wr_data    = {4'h0, i_adc_data, 4'h0, pair_lo_q};
                     pend_d     = 1'b0;
                     word_cnt_d = word_cnt_q + 16'd1;
                  end
               end
               if (wr_issue && (32'(word_cnt_d) == DEPTH_WORDS)) begin
                  // BRAM full: stop here, any later partial word is dropped
                  trunc_d = 1'b1;
                  pend_d  = 1'b0;
                  state_d = StFlush;
               end else if (win_cnt_q == win_lim_q - 32'd1) begin
                  state_d = StFlush;
                  // A lone pending sample is issued now so its enable lands in FLUSH
                  if (pend_d) begin
                     wr_issue   = 1'b1;
                     wr_data    = {20'h0, pair_lo_d};
                     pend_d     = 1'b0;
                     word_cnt_d = word_cnt_q + 16'd1;
                  end
               end
            end
            StFlush: begin
               pend_d  = 1'b0;
               state_d = StDone;
            end
            StDone: begin
               if (i_done_ack) state_d = StIdle;
            end
            default: state_d = StIdle;
         endcase
      end

      ena_d  = wr_issue;
      addr_d = wr_issue ? {14'd0, word_cnt_q, 2'b00} : addr_q;
      data_d = wr_issue ? wr_data : data_q;
   end

   // State and registered BRAM port
   always_ff @(posedge clk_200m) begin
      if (rst) begin
         state_q    <= StIdle;
         win_lim_q  <= '0;
         win_cnt_q  <= '0;
         pend_q     <= 1'b0;
         pair_lo_q  <= '0;
         word_cnt_q <= '0;
         trunc_q    <= 1'b0;
         ena_q      <= 1'b0;
         addr_q     <= '0;
         data_q     <= '0;
      end else begin
         state_q    <= state_d;
         win_lim_q  <= win_lim_d;
         win_cnt_q  <= win_cnt_d;
         pend_q     <= pend_d;
         pair_lo_q  <= pair_lo_d;
         word_cnt_q <= word_cnt_d;
         trunc_q    <= trunc_d;
         ena_q      <= ena_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
      end
   end

   assign o_bram_addr = addr_q;
   assign o_bram_data = data_q;
   assign o_bram_ena  = ena_q;
   assign o_bram_wea  = ena_q;
   assign o_busy      = (state_q == StArmed) || (state_q == StCapture) || (state_q == StFlush);
   assign o_done      = (state_q == StDone);
   assign o_trunc     = trunc_q;
   assign o_word_cnt  = word_cnt_q;
   assign o_state     = state_q;

endmodule

// File: tb/tb_ad9434_cap_ctrl.sv
// Bench for ad9434_cap_ctrl: a vector table of capture scenarios plus hand sequences,
// with a write scoreboard filled by a bench-side packing model.
module tb_ad9434_cap_ctrl;

   logic        clk = 1'b0;
   logic        rst, arm, trig, abort, valid, ack, sel_t;
   logic [9:0]  us;
   logic [11:0] data;

   logic [31:0] a_addr, a_data, t_addr, t_data;
   logic        a_ena, a_wea, a_busy, a_done, a_trunc;
   logic        t_ena, t_wea, t_busy, t_done, t_trunc;
   logic [15:0] a_wc, t_wc;
   logic [2:0]  a_st, t_st;

   logic [31:0] addr_m, data_m;
   logic        ena_m, wea_m, busy_m, done_m, trunc_m;
   logic [15:0] wc_m;
   logic [2:0]  st_m;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      bit          flush;
   } wr_t;
   wr_t q[$];

   typedef struct {
      int n;
      int period;
      int abort_at;
      bit use_t;
      int exp_words;
      bit exp_trunc;
   } vec_t;
   vec_t vecs[5];

   always #5 clk = ~clk;

   ad9434_cap_ctrl dut (
      .clk_200m(clk), .rst(rst), .i_arm(arm & ~sel_t), .i_trig(trig), .i_abort(abort),
      .i_us_capture(us), .i_adc_valid(valid), .i_adc_data(data), .i_done_ack(ack),
      .o_bram_addr(a_addr), .o_bram_data(a_data), .o_bram_ena(a_ena), .o_bram_wea(a_wea),
      .o_busy(a_busy), .o_done(a_done), .o_trunc(a_trunc), .o_word_cnt(a_wc), .o_state(a_st)
   );

   ad9434_cap_ctrl #(.CLK_PER_US(200), .DEPTH_WORDS(8)) dut_t (
      .clk_200m(clk), .rst(rst), .i_arm(arm & sel_t), .i_trig(trig), .i_abort(abort),
      .i_us_capture(us), .i_adc_valid(valid), .i_adc_data(data), .i_done_ack(ack),
      .o_bram_addr(t_addr), .o_bram_data(t_data), .o_bram_ena(t_ena), .o_bram_wea(t_wea),
      .o_busy(t_busy), .o_done(t_done), .o_trunc(t_trunc), .o_word_cnt(t_wc), .o_state(t_st)
   );

   assign addr_m  = sel_t ? t_addr  : a_addr;
   assign data_m  = sel_t ? t_data  : a_data;
   assign ena_m   = sel_t ? t_ena   : a_ena;
   assign wea_m   = sel_t ? t_wea   : a_wea;
   assign busy_m  = sel_t ? t_busy  : a_busy;
   assign done_m  = sel_t ? t_done  : a_done;
   assign trunc_m = sel_t ? t_trunc : a_trunc;
   assign wc_m    = sel_t ? t_wc    : a_wc;
   assign st_m    = sel_t ? t_st    : a_st;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Write monitor: every BRAM enable must match the head of the scoreboard
   always @(negedge clk) begin
      if (!rst && ena_m) begin
         wr_t e;
         chk("wea_eq_ena", 32'(wea_m), 32'd1);
         if (q.size() == 0) begin
            chk("unexpected_write_addr", addr_m, 32'hFFFF_FFFF);
         end else begin
            e = q.pop_front();
            chk("wr_addr", addr_m, e.addr);
            chk("wr_data", data_m, e.data);
            if (e.flush) chk("flush_wr_state", 32'(st_m), 32'd3);
         end
      end
   end

   task automatic run_vec(input int n, input int period, input int abort_at, input bit use_t,
                          input int exp_words, input bit exp_trunc, input bit skip_arm);
      int depth;
      int lim;
      int cnt;
      bit pend, aborted, hit;
      logic [11:0] lo, d;
      depth = use_t ? 8 : 4096;
      lim = n * 200;
      cnt = 0;
      pend = 0;
      aborted = 0;
      hit = 0;
      lo = '0;
      sel_t = use_t;
      if (!skip_arm) begin
         arm = 1'b1;
         cyc();
         arm = 1'b0;
         chk("armed", 32'(st_m), 32'd1);
      end
      us = 10'(n);
      trig = 1'b1;
      repeat (2) @(posedge clk);
      for (int w = 0; w < lim; w++) begin
         cyc();
         if (w == 0) chk("capture_entry", 32'(st_m), 32'd2);
         if (w == abort_at) begin
            abort = 1'b1;
            valid = 1'b0;
            aborted = 1;
            break;
         end
         valid = ((w % period) == 0);
         if (valid) begin
            d = 12'($urandom);
            data = d;
            if (!pend) begin
               pend = 1;
               lo = d;
            end else begin
               q.push_back('{addr: 32'(cnt * 4), data: {4'h0, d, 4'h0, lo}, flush: 1'b0});
               pend = 0;
               cnt++;
               if (cnt == depth) begin
                  hit = 1;
                  break;
               end
            end
         end
      end
      if (!aborted && !hit && pend) begin
         q.push_back('{addr: 32'(cnt * 4), data: {20'h0, lo}, flush: 1'b1});
         cnt++;
      end
      cyc();
      valid = 1'b0;
      trig = 1'b0;
      if (aborted) begin
         abort = 1'b0;
         chk("abort_idle", 32'(st_m), 32'd0);
         chk("abort_cnt", 32'(wc_m), 32'(exp_words));
         repeat (3) begin
            cyc();
            chk("abort_no_done", 32'(done_m), 32'd0);
         end
      end else begin
         chk("flush_state", 32'(st_m), 32'd3);
         chk("flush_busy", 32'(busy_m), 32'd1);
         cyc();
         chk("done_state", 32'(st_m), 32'd4);
         chk("done", 32'(done_m), 32'd1);
         chk("done_busy", 32'(busy_m), 32'd0);
         chk("word_cnt", 32'(wc_m), 32'(exp_words));
         chk("trunc", 32'(trunc_m), 32'(exp_trunc));
         repeat (3) cyc();
         chk("done_hold", 32'(done_m), 32'd1);
         ack = 1'b1;
         cyc();
         ack = 1'b0;
         chk("ack_idle", 32'(st_m), 32'd0);
         chk("ack_done_low", 32'(done_m), 32'd0);
         chk("cnt_kept", 32'(wc_m), 32'(exp_words));
         chk("trunc_kept", 32'(trunc_m), 32'(exp_trunc));
      end
      repeat (4) cyc();
      chk("sb_drained", 32'(q.size()), 32'd0);
      q.delete();
      sel_t = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [11:0] d;
      logic [11:0] lo;
      rst = 1'b1; arm = 1'b0; trig = 1'b0; abort = 1'b0; valid = 1'b0; ack = 1'b0;
      sel_t = 1'b0; us = '0; data = '0;
      vecs[0] = '{n: 1, period: 1, abort_at: -1, use_t: 1'b0, exp_words: 100, exp_trunc: 1'b0};
      vecs[1] = '{n: 1, period: 3, abort_at: -1, use_t: 1'b0, exp_words: 34, exp_trunc: 1'b0};
      vecs[2] = '{n: 1, period: 1, abort_at: -1, use_t: 1'b1, exp_words: 8, exp_trunc: 1'b1};
      vecs[3] = '{n: 1, period: 1, abort_at: 50, use_t: 1'b0, exp_words: 25, exp_trunc: 1'b0};
      vecs[4] = '{n: 2, period: 2, abort_at: -1, use_t: 1'b0, exp_words: 200, exp_trunc: 1'b0};
      // period 2 over 400 cycles: 200 samples, 100 words
      vecs[4].exp_words = 100;

      repeat (3) cyc();
      rst = 1'b0;
      chk("rst_state", 32'(st_m), 32'd0);
      chk("rst_ena", 32'(ena_m), 32'd0);
      chk("rst_addr", addr_m, 32'd0);
      chk("rst_data", data_m, 32'd0);
      chk("rst_busy", 32'(busy_m), 32'd0);
      chk("rst_done", 32'(done_m), 32'd0);
      chk("rst_wc", 32'(wc_m), 32'd0);
      cyc();

      for (int i = 0; i < 5; i++) begin
         run_vec(vecs[i].n, vecs[i].period, vecs[i].abort_at, vecs[i].use_t,
                 vecs[i].exp_words, vecs[i].exp_trunc, 1'b0);
      end

      // Trigger in IDLE is not remembered; ack outside DONE is ignored; N = 0 capture
      trig = 1'b1;
      repeat (3) cyc();
      trig = 1'b0;
      repeat (4) cyc();
      arm = 1'b1;
      cyc();
      arm = 1'b0;
      repeat (6) cyc();
      chk("idle_trig_ignored", 32'(st_m), 32'd1);
      ack = 1'b1;
      cyc();
      ack = 1'b0;
      chk("ack_in_armed", 32'(st_m), 32'd1);
      run_vec(0, 1, -1, 1'b0, 0, 1'b0, 1'b1);

      // Reset mid-capture with a pending sample
      arm = 1'b1;
      cyc();
      arm = 1'b0;
      us = 10'd1;
      trig = 1'b1;
      repeat (2) @(posedge clk);
      lo = '0;
      for (int w = 0; w < 6; w++) begin
         cyc();
         if (w < 5) begin
            d = 12'($urandom);
            valid = 1'b1;
            data = d;
            if ((w % 2) == 0) lo = d;
            else q.push_back('{addr: 32'((w / 2) * 4), data: {4'h0, d, 4'h0, lo}, flush: 1'b0});
         end else begin
            valid = 1'b0;
            rst = 1'b1;
         end
      end
      cyc();
      rst = 1'b0;
      trig = 1'b0;
      chk("midrst_state", 32'(st_m), 32'd0);
      chk("midrst_ena", 32'(ena_m), 32'd0);
      chk("midrst_addr", addr_m, 32'd0);
      chk("midrst_data", data_m, 32'd0);
      chk("midrst_busy", 32'(busy_m), 32'd0);
      chk("midrst_wc", 32'(wc_m), 32'd0);
      chk("midrst_trunc", 32'(trunc_m), 32'd0);
      chk("midrst_sb", 32'(q.size()), 32'd0);
      q.delete();
      repeat (4) cyc();
      run_vec(1, 2, -1, 1'b0, 50, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
